// File: rtl/flop_checker_pkg.sv
// Shared types and constants for the flop response checker.
package flop_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_PLAIN   = 2'd0;
  localparam logic [1:0] MODE_SRST    = 2'd1;
  localparam logic [1:0] MODE_SRST_EN = 2'd2;

  localparam int MAX_LATENCY = 4;

endpackage

// File: rtl/flop_checker_ref_model.sv
// Reference model of the flop under test plus a valid-tagged delay line that
// lines the prediction up with the DUT output LATENCY cycles later.
// Mode 3 behaves like sync reset + enable.
module flop_ref_model
  import flop_checker_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             dut_rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] exp_t,
  output logic             exp_vld,
  output logic             exp_vld_nxt
);

  // Stage 0 is the model register itself; later stages only delay it.
  logic [WIDTH-1:0]   exp_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   exp_nxt;
  logic [WIDTH-1:0]   srst_en_val;

  // Predict what the selected flop variant holds after this cycle's stimulus.
  always_comb begin
    srst_en_val = !dut_rst_n ? '0 : (en ? d : exp_q[0]);
    exp_nxt     = exp_q[0];
    case (mode)
      MODE_PLAIN:   exp_nxt = d;
      MODE_SRST:    exp_nxt = dut_rst_n ? d : '0;
      MODE_SRST_EN: exp_nxt = srst_en_val;
      default:      exp_nxt = srst_en_val;
    endcase
  end

  // Advance the model while a run is active and shift data/valid down the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) exp_q[k] <= '0;
      vld_q <= '0;
    end else begin
      if (busy) exp_q[0] <= exp_nxt;
      for (int k = 1; k < LATENCY; k++) exp_q[k] <= exp_q[k-1];
      if (clr) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= busy;
        for (int k = 1; k < LATENCY; k++) vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign exp_t   = exp_q[LATENCY-1];
  assign exp_vld = vld_q[LATENCY-1];

  // Look-ahead of the tail valid bit so the FSM can enter CHECK exactly when
  // the first aligned prediction reaches the tail.
  if (LATENCY == 1) begin : g_nxt_direct
    assign exp_vld_nxt = busy;
  end else begin : g_nxt_stage
    assign exp_vld_nxt = vld_q[LATENCY-2];
  end

endmodule

// File: rtl/flop_checker.sv
// Response checker for plain / sync-reset / sync-reset-with-enable flops.
// Optional first-mismatch capture is enabled by defining FLOP_CHECKER_FIRST_ERR_EN.
module flop_checker
  import flop_checker_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             dut_rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q_dut,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             done,
  output logic             pass
`ifdef FLOP_CHECKER_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_obs
`endif
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_latency_range
    $error("flop_checker: LATENCY must be in 1..%0d", MAX_LATENCY);
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic             run_active;
  logic             arm_entry;
  logic             compare;
  logic             neq;
  logic             miss;
  logic [WIDTH-1:0] exp_t;
  logic             exp_vld;
  logic             exp_vld_nxt;

  assign run_active = (state == ARM) || (state == CHECK);
  assign arm_entry  = start && ((state == IDLE) || (state == DONE));
  assign compare    = (state == CHECK) && exp_vld;

`ifdef SYNTHESIS
  assign neq = (q_dut != exp_t);
`else
  assign neq = (q_dut !== exp_t);
`endif
  assign miss = compare && neq;

  flop_ref_model #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_ref (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy       (run_active),
    .clr        (arm_entry),
    .mode       (mode),
    .dut_rst_n  (dut_rst_n),
    .en         (en),
    .d          (d),
    .exp_t      (exp_t),
    .exp_vld    (exp_vld),
    .exp_vld_nxt(exp_vld_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: start wins when idle/done, stop wins while a run is active.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (stop) state_nxt = DONE;
               else if (exp_vld_nxt) state_nxt = CHECK;
      CHECK:   if (stop) state_nxt = DONE;
      DONE:    if (start) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the current state and final counts.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      ARM, CHECK: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (err_cnt == '0) && (check_cnt != '0);
      end
      default: ;
    endcase
  end

  // Saturating check/error counters and the registered mismatch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_cnt <= '0;
      err_cnt   <= '0;
      mismatch  <= 1'b0;
    end else if (arm_entry) begin
      check_cnt <= '0;
      err_cnt   <= '0;
      mismatch  <= 1'b0;
    end else begin
      mismatch <= miss;
      if (compare && (check_cnt != CNT_MAX)) check_cnt <= check_cnt + CNT_W'(1);
      if (miss && (err_cnt != CNT_MAX))      err_cnt   <= err_cnt + CNT_W'(1);
    end
  end

`ifdef FLOP_CHECKER_FIRST_ERR_EN
  // Capture index and operands of the first mismatch of a run only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_obs <= '0;
    end else if (arm_entry) begin
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_obs <= '0;
    end else if (miss && (err_cnt == '0)) begin
      first_err_idx <= check_cnt;
      first_err_exp <= exp_t;
      first_err_obs <= q_dut;
    end
  end
`endif

endmodule

// File: tb/tb_flop_checker.sv
// Randomized self-checking bench for flop_checker. Two checkers share one
// stimulus stream: a 4-bit LATENCY=2 instance and a 1-bit LATENCY=3 instance
// with 4-bit counters to exercise saturation. Honors FLOP_CHECKER_FIRST_ERR_EN.
module tb_flop_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       dut_rst_n;
  logic       en;
  logic [3:0] d;
  logic [3:0] q_main;
  logic       q_small;

  logic        busy_m, mismatch_m, done_m, pass_m;
  logic [15:0] check_m, err_m;
  logic        busy_s, mismatch_s, done_s, pass_s;
  logic [3:0]  check_s, err_s;
`ifdef FLOP_CHECKER_FIRST_ERR_EN
  logic [15:0] fidx_m;
  logic [3:0]  fexp_m, fobs_m;
  logic [3:0]  fidx_s;
  logic        fexp_s, fobs_s;
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  flop_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(16)) dut_main (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .dut_rst_n(dut_rst_n), .en(en), .d(d), .q_dut(q_main),
    .busy(busy_m), .mismatch(mismatch_m), .check_cnt(check_m), .err_cnt(err_m),
    .done(done_m), .pass(pass_m)
`ifdef FLOP_CHECKER_FIRST_ERR_EN
    , .first_err_idx(fidx_m), .first_err_exp(fexp_m), .first_err_obs(fobs_m)
`endif
  );

  flop_checker #(.WIDTH(1), .LATENCY(3), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .dut_rst_n(dut_rst_n), .en(en), .d(d[0]), .q_dut(q_small),
    .busy(busy_s), .mismatch(mismatch_s), .check_cnt(check_s), .err_cnt(err_s),
    .done(done_s), .pass(pass_s)
`ifdef FLOP_CHECKER_FIRST_ERR_EN
    , .first_err_idx(fidx_s), .first_err_exp(fexp_s), .first_err_obs(fobs_s)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input logic [1:0] md,
                               input bit drn, input bit e, input logic [3:0] dv,
                               input logic [3:0] qm, input logic qs);
    start     = st;
    stop      = sp;
    mode      = md;
    dut_rst_n = drn;
    en        = e;
    d         = dv;
    q_main    = qm;
    q_small   = qs;
  endtask

  // Value a correct flop of the given variant holds after one stimulus cycle.
  function automatic logic [3:0] nextFlop(input logic [1:0] md, input logic [3:0] prev,
                                          input logic [3:0] dv, input bit drn, input bit e);
    if (md == 2'd0) return dv;
    if (!drn) return 4'd0;
    if (md == 2'd1 || e) return dv;
    return prev;
  endfunction

  // One run: start in cycle 0, busy cycles 1..n, stop in cycle n.
  // A DUT with latency L is compared in cycles L+1..n against stimulus of cycle c-L.
  task automatic runCheck(input int n, input int md, input int err_pct, input int xcyc);
    logic [3:0] ref_val [0:63];
    bit         bad_m [0:63];
    bit         bad_s [0:63];
    logic [3:0] qm, dv, prev;
    logic       qs;
    bit         st, sp, drn, e;
    int         chk_m, er_m, chk_s, er_s;
    bit         seen_m, seen_s;
    int         idx_m, idx_s;
    logic [3:0] f_exp_m, f_obs_m;
    logic       f_exp_s, f_obs_s;
    for (int i = 0; i < 64; i++) begin
      ref_val[i] = '0;
      bad_m[i]   = 1'b0;
      bad_s[i]   = 1'b0;
    end
    chk_m = 0; er_m = 0; chk_s = 0; er_s = 0;
    seen_m = 0; seen_s = 0; idx_m = 0; idx_s = 0;
    f_exp_m = '0; f_obs_m = '0; f_exp_s = 1'b0; f_obs_s = 1'b0;
    prev = '0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        checkOutput("busy_m", 32'(busy_m), 32'd1);
        checkOutput("mismatch_m", 32'(mismatch_m), 32'(bad_m[c-1]));
        checkOutput("mismatch_s", 32'(mismatch_s), 32'(bad_s[c-1]));
      end
      st  = (c == 0) || ($urandom_range(0, 7) == 0);
      sp  = (c == n) || ((c == 0) && ($urandom_range(0, 1) == 1));
      dv  = 4'($urandom);
      e   = (c == 1) || ($urandom_range(0, 1) == 1);
      drn = ($urandom_range(0, 3) != 0);
      if (c >= 1) begin
        prev = nextFlop(2'(md), prev, dv, drn, e);
        ref_val[c] = prev;
      end
      qm = 4'($urandom);
      if (c >= 3) begin
        qm = ref_val[c-2];
        if ($urandom_range(0, 99) < err_pct) begin
          qm = qm ^ 4'($urandom_range(1, 15));
          bad_m[c] = 1'b1;
        end
        if (c == xcyc) begin
          qm = 4'bxxxx;
          bad_m[c] = 1'b1;
        end
        if (bad_m[c] && !seen_m) begin
          seen_m = 1; idx_m = chk_m; f_exp_m = ref_val[c-2]; f_obs_m = qm;
        end
        chk_m++;
        if (bad_m[c]) er_m++;
      end
      qs = 1'($urandom);
      if (c >= 4) begin
        qs = ref_val[c-3][0];
        if ($urandom_range(0, 99) < err_pct) begin
          qs = ~qs;
          bad_s[c] = 1'b1;
        end
        if (bad_s[c] && !seen_s) begin
          seen_s = 1; idx_s = chk_s; f_exp_s = ref_val[c-3][0]; f_obs_s = qs;
        end
        if (chk_s < 15) chk_s++;
        if (bad_s[c] && er_s < 15) er_s++;
      end
      applyStimulus(st, sp, 2'(md), drn, e, dv, qm, qs);
    end
    @(negedge clk);
    checkOutput("mismatch_m_last", 32'(mismatch_m), 32'(bad_m[n]));
    checkOutput("mismatch_s_last", 32'(mismatch_s), 32'(bad_s[n]));
    checkOutput("busy_m_end", 32'(busy_m), 32'd0);
    checkOutput("done_m", 32'(done_m), 32'd1);
    checkOutput("done_s", 32'(done_s), 32'd1);
    checkOutput("check_cnt_m", 32'(check_m), 32'(chk_m));
    checkOutput("err_cnt_m", 32'(err_m), 32'(er_m));
    checkOutput("pass_m", 32'(pass_m), 32'((er_m == 0) && (chk_m != 0)));
    checkOutput("check_cnt_s", 32'(check_s), 32'(chk_s));
    checkOutput("err_cnt_s", 32'(err_s), 32'(er_s));
    checkOutput("pass_s", 32'(pass_s), 32'((er_s == 0) && (chk_s != 0)));
`ifdef FLOP_CHECKER_FIRST_ERR_EN
    checkOutput("first_idx_m", 32'(fidx_m), 32'(idx_m));
    checkOutput("first_exp_m", 32'(fexp_m), 32'(f_exp_m));
    checkOutput("first_obs_m", 32'(fobs_m), 32'(f_obs_m));
    checkOutput("first_idx_s", 32'(fidx_s), 32'(idx_s));
    checkOutput("first_exp_s", 32'(fexp_s), 32'(f_exp_s));
    checkOutput("first_obs_s", 32'(fobs_s), 32'(f_obs_s));
`endif
    applyStimulus(1'b0, 1'b0, 2'(md), 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    checkOutput("done_hold_m", 32'(done_m), 32'd1);
    checkOutput("check_hold_m", 32'(check_m), 32'(chk_m));
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_m), 32'd0);
    checkOutput({tag, "_mismatch"}, 32'(mismatch_m), 32'd0);
    checkOutput({tag, "_check_cnt"}, 32'(check_m), 32'd0);
    checkOutput({tag, "_err_cnt"}, 32'(err_m), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_m), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass_m), 32'd0);
    checkOutput({tag, "_err_cnt_s"}, 32'(err_s), 32'd0);
`ifdef FLOP_CHECKER_FIRST_ERR_EN
    checkOutput({tag, "_first_idx"}, 32'(fidx_m), 32'd0);
    checkOutput({tag, "_first_obs"}, 32'(fobs_m), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    checkAllClear("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Short clean runs, including ones too short to reach any compare.
    runCheck(5, 0, 0, -1);
    runCheck(1, 0, 0, -1);
    runCheck(3, 2, 0, -1);
    // Random runs across all four mode encodings with sporadic corruption.
    for (int i = 0; i < 12; i++) runCheck($urandom_range(4, 30), i % 4, 20, -1);
    // Every compare corrupted: the 4-bit counters must saturate at 15.
    runCheck(40, 2, 100, -1);
    // Unknown value on q_dut counts as a mismatch.
    runCheck(12, 1, 0, 8);

    // Reset in the middle of a run aborts it and clears every output.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
    end
    @(negedge clk);
    checkOutput("busy_before_abort", 32'(busy_m), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkAllClear("abort");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    runCheck(10, 3, 30, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
